// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and constants for 68000 bus cycle termination
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_WAIT   = 3'd2,
    ST_ACK    = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  // Chip-select indices double as priority: lower index wins.
  localparam logic [3:0] CS_UNMAP = 4'd0;
  localparam logic [3:0] CS_CTRL  = 4'd1;
  localparam logic [3:0] CS_PGTBL = 4'd2;
  localparam logic [3:0] CS_IO    = 4'd3;
  localparam logic [3:0] CS_GFX   = 4'd4;
  localparam logic [3:0] CS_ROM   = 4'd5;
  localparam logic [3:0] CS_RAM1  = 4'd6;
  localparam logic [3:0] CS_RAM2  = 4'd7;
  localparam logic [3:0] CS_NONE  = 4'd8;
  localparam int         CS_NUM   = 8;

  localparam int DEF_CTRL_WS  = 1;
  localparam int DEF_PGTBL_WS = 1;
  localparam int DEF_IO_WS    = 6;
  localparam int DEF_GFX_WS   = 2;
  localparam int DEF_ROM_WS   = 4;
  localparam int DEF_RAM_WS   = 2;
  localparam int DEF_TIMEOUT  = 255;
  localparam int DEF_CNT_W    = 8;

  function automatic logic [3:0] cs_pick(input logic [CS_NUM-1:0] cs);
    logic [3:0] sel;
    sel = CS_NONE;
    for (int i = CS_NUM - 1; i >= 0; i--) begin
      if (cs[i]) sel = 4'(i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with async active-low reset
module sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_q    <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/bus_term.sv
// rtl/bus_term.sv - 68000 bus cycle terminator with wait states and watchdog
module bus_term
  import bus_pkg::*;
#(
  parameter int CTRL_WS  = DEF_CTRL_WS,
  parameter int PGTBL_WS = DEF_PGTBL_WS,
  parameter int IO_WS    = DEF_IO_WS,
  parameter int GFX_WS   = DEF_GFX_WS,
  parameter int ROM_WS   = DEF_ROM_WS,
  parameter int RAM_WS   = DEF_RAM_WS,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset_n,
  input  logic as_n,
  input  logic csunmap,
  input  logic csctrl,
  input  logic cspgtbl,
  input  logic csio,
  input  logic csgfx,
  input  logic csrom,
  input  logic csram1,
  input  logic csram2,
  input  logic gfx_ready,
  output logic map_enable,
  output logic dtack_n,
  output logic berr_n
);

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_wcnt;
  logic [CNT_W-1:0]   r_wd;
  logic               r_gfx;
  logic               r_nodev;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_wcnt_nxt;
  logic [CNT_W-1:0]   w_wd_nxt;
  logic               w_gfx_nxt;
  logic               w_nodev_nxt;

  logic               w_as_n_s;
  logic               w_as_s;
  logic [CS_NUM-1:0]  w_cs;
  logic [3:0]         w_sel;
  logic [CNT_W-1:0]   w_ws;

  sync2 #(.RESET_VAL(1'b1)) u_as_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (as_n),
    .o_q     (w_as_n_s)
  );

  assign w_as_s = ~w_as_n_s;
  assign w_cs   = {csram2, csram1, csrom, csgfx, csio, cspgtbl, csctrl, csunmap};
  assign w_sel  = cs_pick(w_cs);

  always_comb begin
    w_ws = '0;
    case (w_sel)
      CS_CTRL:  w_ws = CNT_W'(CTRL_WS);
      CS_PGTBL: w_ws = CNT_W'(PGTBL_WS);
      CS_IO:    w_ws = CNT_W'(IO_WS);
      CS_GFX:   w_ws = CNT_W'(GFX_WS);
      CS_ROM:   w_ws = CNT_W'(ROM_WS);
      CS_RAM1:  w_ws = CNT_W'(RAM_WS);
      CS_RAM2:  w_ws = CNT_W'(RAM_WS);
      default:  w_ws = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
      r_wd    <= '0;
      r_gfx   <= 1'b0;
      r_nodev <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_wd    <= w_wd_nxt;
      r_gfx   <= w_gfx_nxt;
      r_nodev <= w_nodev_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_wd_nxt    = r_wd;
    w_gfx_nxt   = r_gfx;
    w_nodev_nxt = r_nodev;
    case (r_state)
      ST_IDLE: begin
        if (w_as_s) w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (!w_as_s) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_wd_nxt    = '0;
          w_gfx_nxt   = (w_sel == CS_GFX);
          w_nodev_nxt = (w_sel == CS_NONE);
          if (w_sel == CS_UNMAP) begin
            w_state_nxt = ST_ERR;
          end else if (w_sel == CS_NONE) begin
            // Saturated and frozen: only the watchdog can end this cycle.
            w_wcnt_nxt  = '1;
            w_state_nxt = ST_WAIT;
          end else if (w_ws == '0) begin
            w_state_nxt = ST_ACK;
          end else begin
            w_wcnt_nxt  = w_ws - CNT_W'(1);
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!w_as_s) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_wd_nxt = r_wd + CNT_W'(1);
          if (r_wd == WD_LAST) begin
            w_state_nxt = ST_ERR;
          end else if (!r_nodev && r_wcnt == '0 && (!r_gfx || gfx_ready)) begin
            w_state_nxt = ST_ACK;
          end else if (!r_nodev && r_wcnt != '0) begin
            w_wcnt_nxt = r_wcnt - CNT_W'(1);
          end
        end
      end
      ST_ACK, ST_ERR: begin
        if (!w_as_s) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    map_enable = (r_state != ST_IDLE);
    dtack_n    = (r_state != ST_ACK);
    berr_n     = (r_state != ST_ERR);
  end

endmodule

// File: tb/tb_bus_term.sv
// tb/tb_bus_term.sv - directed vector bench for bus_term
module tb_bus_term;

  logic clk = 1'b0;
  logic reset_n;
  logic as_n;
  logic csunmap, csctrl, cspgtbl, csio, csgfx, csrom, csram1, csram2;
  logic gfx_ready;
  logic map_enable, dtack_n, berr_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] cs;
    logic       rdy;
    int         dt_edge;
    int         be_edge;
  } vec_t;

  vec_t vecs[14];

  always #10 clk = ~clk;

  bus_term dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .as_n       (as_n),
    .csunmap    (csunmap),
    .csctrl     (csctrl),
    .cspgtbl    (cspgtbl),
    .csio       (csio),
    .csgfx      (csgfx),
    .csrom      (csrom),
    .csram1     (csram1),
    .csram2     (csram2),
    .gfx_ready  (gfx_ready),
    .map_enable (map_enable),
    .dtack_n    (dtack_n),
    .berr_n     (berr_n)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cs(input logic [7:0] v);
    {csram2, csram1, csrom, csgfx, csio, cspgtbl, csctrl, csunmap} = v;
  endtask

  task automatic run_cycle(input string name, input int dt_exp, input int be_exp);
    int dt   = -1;
    int be   = -1;
    int both = 0;
    int held = 0;
    as_n = 1'b0;
    for (int e = 0; e < 300; e++) begin
      tick();
      if (!dtack_n && !berr_n) both++;
      if (!dtack_n && dt < 0) dt = e;
      if (!berr_n && be < 0) be = e;
      if (dt >= 0 || be >= 0) break;
    end
    check({name, " dtack edge"}, dt, dt_exp);
    check({name, " berr edge"}, be, be_exp);
    as_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (!dtack_n && !berr_n) both++;
      if (k < 3 && (!dtack_n || !berr_n)) held++;
    end
    check({name, " held until release"}, held, 2);
    check({name, " outputs released"}, int'({dtack_n, berr_n, map_enable}), 6);
    check({name, " dtack berr overlap"}, both, 0);
    tick();
    tick();
  endtask

  initial begin
    int early;
    int seen;
    int me_cnt;

    vecs[0]  = '{"ctrl",        8'h02, 1'b1, 4,   -1};
    vecs[1]  = '{"pgtbl",       8'h04, 1'b1, 4,   -1};
    vecs[2]  = '{"io",          8'h08, 1'b1, 9,   -1};
    vecs[3]  = '{"gfx ready",   8'h10, 1'b1, 5,   -1};
    vecs[4]  = '{"rom",         8'h20, 1'b1, 7,   -1};
    vecs[5]  = '{"ram1",        8'h40, 1'b1, 5,   -1};
    vecs[6]  = '{"ram2",        8'h80, 1'b1, 5,   -1};
    vecs[7]  = '{"unmap",       8'h01, 1'b1, -1,  3};
    vecs[8]  = '{"unmap+ram1",  8'h41, 1'b1, -1,  3};
    vecs[9]  = '{"ctrl+io",     8'h0A, 1'b1, 4,   -1};
    vecs[10] = '{"io+rom",      8'h28, 1'b1, 9,   -1};
    vecs[11] = '{"rom+ram2",    8'hA0, 1'b1, 7,   -1};
    vecs[12] = '{"gfx+rom stall", 8'h30, 1'b0, -1, 258};
    vecs[13] = '{"no select",   8'h00, 1'b1, -1,  258};

    reset_n   = 1'b0;
    as_n      = 1'b1;
    gfx_ready = 1'b0;
    set_cs(8'h00);
    tick();
    tick();
    check("reset map_enable", int'(map_enable), 0);
    check("reset dtack_n", int'(dtack_n), 1);
    check("reset berr_n", int'(berr_n), 1);
    #5 reset_n = 1'b1;
    tick();
    tick();
    check("idle after reset", int'({map_enable, dtack_n, berr_n}), 3);

    for (int i = 0; i < 14; i++) begin
      set_cs(vecs[i].cs);
      gfx_ready = vecs[i].rdy;
      run_cycle(vecs[i].name, vecs[i].dt_edge, vecs[i].be_edge);
      set_cs(8'h00);
    end

    // Graphics stall released by gfx_ready after 25 edges
    set_cs(8'h10);
    gfx_ready = 1'b0;
    as_n = 1'b0;
    early = 0;
    for (int e = 0; e < 25; e++) begin
      tick();
      if (!dtack_n || !berr_n) early++;
    end
    check("gfx stall early term", early, 0);
    gfx_ready = 1'b1;
    tick();
    check("gfx ack after ready", int'({dtack_n, berr_n}), 1);
    as_n = 1'b1;
    tick();
    tick();
    tick();
    check("gfx release", int'({dtack_n, map_enable}), 2);
    tick();
    tick();

    // Abort: as_n raised before edge 5 of a ROM cycle
    set_cs(8'h20);
    as_n = 1'b0;
    seen = 0;
    for (int e = 0; e <= 4; e++) begin
      tick();
      if (!dtack_n || !berr_n) seen++;
    end
    as_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (!dtack_n || !berr_n) seen++;
    end
    check("abort map_enable", int'(map_enable), 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (!dtack_n || !berr_n) seen++;
    end
    check("abort no termination", seen, 0);
    run_cycle("after abort rom", 7, -1);

    // Asynchronous reset while in ACK
    set_cs(8'h40);
    as_n = 1'b0;
    for (int e = 0; e <= 5; e++) tick();
    check("pre-reset ack", int'(dtack_n), 0);
    #3 reset_n = 1'b0;
    #1;
    check("async reset dtack_n", int'(dtack_n), 1);
    check("async reset map_enable", int'(map_enable), 0);
    check("async reset berr_n", int'(berr_n), 1);
    as_n = 1'b1;
    #4 reset_n = 1'b1;
    me_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (map_enable || !dtack_n || !berr_n) me_cnt++;
    end
    check("idle after async reset", me_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
